// File: rtl/ber_checker_pkg.sv
// Shared constants, FSM encoding and delay helper for the PRBS9 BER checker.
package ber_checker_pkg;

    localparam int PRBS_PERIOD = 511;
    localparam int DLY_W       = 9;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(PRBS_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Candidate delay advance; 510 wraps back to 0.
    function automatic logic [DLY_W-1:0] delay_next(input logic [DLY_W-1:0] d);
        return (d == DLY_LAST) ? '0 : DLY_W'(d + 1'b1);
    endfunction

endpackage

// File: rtl/ber_delay_line.sv
// Reference-bit history with a tap mux: tap d is the reference bit from d strobes ago,
// tap 0 being the bit presented on the current strobe.
module ber_delay_line
    import ber_checker_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_shift,
    input  logic             i_ref_bit,
    input  logic [DLY_W-1:0] i_tap,
    output logic             o_tap_bit
);

    logic [PRBS_PERIOD-2:0] line;
    logic [PRBS_PERIOD-1:0] taps;

    assign taps      = {line, i_ref_bit};
    assign o_tap_bit = taps[i_tap];

    always_ff @(posedge clock) begin
        if (reset)
            line <= '0;
        else if (i_shift)
            line <= {line[PRBS_PERIOD-3:0], i_ref_bit};
    end

endmodule

// File: rtl/ber_checker.sv
// PRBS9 bit-error-rate checker: fill, delay search, then locked error counting.
// Optional BER_RELOCK_EN adds a locked-state error window that drops back to SEARCH.
module ber_checker
    import ber_checker_pkg::*;
#(
    parameter int NB_COUNT       = 64,
    parameter int LOCK_ERR_MAX   = 0,
    parameter int RELOCK_ERR_MAX = 64
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic                i_ref_bit,
    input  logic                i_rx_bit,
    output logic                o_locked,
    output logic [DLY_W-1:0]    o_delay,
    output logic [NB_COUNT-1:0] o_bit_count,
    output logic [NB_COUNT-1:0] o_error_count,
    output logic                o_ber_zero
);

    if (NB_COUNT < 1 || LOCK_ERR_MAX < 0 || RELOCK_ERR_MAX < 0) begin : g_param_check
        $error("ber_checker: illegal parameter value");
    end

    state_t           state, next_state;
    logic [DLY_W-1:0] fill_cnt, win_cnt, win_err, win_err_tot;
    logic             qual, tap_bit, mismatch, win_end, fill_end, win_pass;

    assign qual        = i_valid & i_enable;
    assign mismatch    = i_rx_bit ^ tap_bit;
    assign win_end     = (win_cnt == DLY_LAST);
    assign fill_end    = (fill_cnt == DLY_LAST);
    // A window holds at most 511 strobes, so the running total fits in 9 bits.
    assign win_err_tot = DLY_W'(win_err + DLY_W'(mismatch));
    assign win_pass    = int'(win_err_tot) <= LOCK_ERR_MAX;

`ifdef BER_RELOCK_EN
    logic win_fail;
    assign win_fail = int'(win_err_tot) > RELOCK_ERR_MAX;
`endif

    ber_delay_line u_delay_line (
        .clock     (clock),
        .reset     (i_reset),
        .i_shift   (qual),
        .i_ref_bit (i_ref_bit),
        .i_tap     (o_delay),
        .o_tap_bit (tap_bit)
    );

    always_ff @(posedge clock) begin
        if (i_reset)
            state <= ST_FILL;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (qual) begin
            case (state)
                ST_FILL:   if (fill_end) next_state = ST_SEARCH;
                ST_SEARCH: if (win_end && win_pass) next_state = ST_LOCKED;
                ST_LOCKED: begin
`ifdef BER_RELOCK_EN
                    if (win_end && win_fail) next_state = ST_SEARCH;
`endif
                end
                default:   next_state = ST_FILL;
            endcase
        end
    end

    always_comb begin
        o_locked   = (state == ST_LOCKED);
        o_ber_zero = o_locked && (o_error_count == '0);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            fill_cnt      <= '0;
            win_cnt       <= '0;
            win_err       <= '0;
            o_delay       <= '0;
            o_bit_count   <= '0;
            o_error_count <= '0;
        end else if (qual) begin
            case (state)
                ST_FILL: begin
                    fill_cnt <= fill_end ? '0 : DLY_W'(fill_cnt + 1'b1);
                    if (fill_end) begin
                        o_delay <= '0;
                        win_cnt <= '0;
                        win_err <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (win_end) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (!win_pass) o_delay <= delay_next(o_delay);
                    end else begin
                        win_cnt <= DLY_W'(win_cnt + 1'b1);
                        win_err <= win_err_tot;
                    end
                end
                ST_LOCKED: begin
                    // Both counters stick at all-ones rather than wrapping.
                    if (~&o_bit_count)
                        o_bit_count <= o_bit_count + 1'b1;
                    if (mismatch && ~&o_error_count)
                        o_error_count <= o_error_count + 1'b1;
`ifdef BER_RELOCK_EN
                    if (win_end) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (win_fail) o_delay <= delay_next(o_delay);
                    end else begin
                        win_cnt <= DLY_W'(win_cnt + 1'b1);
                        win_err <= win_err_tot;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ber_checker.sv
// Scoreboarded bench for ber_checker: a strobe-level reference model predicts every
// clock's outputs for a 64-bit and a 4-bit counter instance driven by the same PRBS9 stimulus.
module tb_ber_checker;

    logic       clock = 1'b0;
    logic       i_reset = 1'b1, i_enable = 1'b0, i_valid = 1'b0, i_ref_bit = 1'b0, i_rx_bit = 1'b0;
    logic       lk64, bz64, lk4, bz4;
    logic [8:0] dl64, dl4;
    logic [63:0] bits64, errs64;
    logic [3:0]  bits4, errs4;

    always #5 clock = ~clock;

    ber_checker dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit), .o_locked(lk64), .o_delay(dl64),
        .o_bit_count(bits64), .o_error_count(errs64), .o_ber_zero(bz64)
    );

    ber_checker #(.NB_COUNT(4)) dut4 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit), .o_locked(lk4), .o_delay(dl4),
        .o_bit_count(bits4), .o_error_count(errs4), .o_ber_zero(bz4)
    );

    typedef struct {
        bit             locked;
        bit [8:0]       delay;
        longint unsigned bits, errs;
        bit             bz;
        int             b4, e4;
        bit             bz4;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0, miscompares = 0;

    task automatic cmp(input string name, input longint unsigned act, input longint unsigned req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model (strobe level) ----------------
    int              m_mode;   // 0 fill, 1 search, 2 locked
    int              m_fill, m_delay, m_b4, m_e4;
    longint unsigned m_bits, m_errs;
    bit              hist[$];  // hist[d] = reference bit from d strobes ago
    bit              win[$];   // per-strobe mismatches of the current window

    function automatic int win_errors();
        int n = 0;
        foreach (win[i]) n += int'(win[i]);
        return n;
    endfunction

    task automatic model(input bit rst, input bit en, input bit vld, input bit r, input bit x);
        bit e;
        if (rst) begin
            m_mode = 0; m_fill = 0; m_delay = 0; m_bits = 0; m_errs = 0; m_b4 = 0; m_e4 = 0;
            hist.delete(); win.delete();
        end else if (en && vld) begin
            hist.push_front(r);
            if (hist.size() > 511) void'(hist.pop_back());
            case (m_mode)
                0: begin
                    m_fill++;
                    if (m_fill == 511) begin m_mode = 1; m_delay = 0; win.delete(); end
                end
                1: begin
                    win.push_back(x != hist[m_delay]);
                    if (win.size() == 511) begin
                        if (win_errors() <= 0) m_mode = 2;
                        else m_delay = (m_delay + 1) % 511;
                        win.delete();
                    end
                end
                default: begin
                    e = (x != hist[m_delay]);
                    if (m_bits != 64'hFFFF_FFFF_FFFF_FFFF) m_bits++;
                    if (e && m_errs != 64'hFFFF_FFFF_FFFF_FFFF) m_errs++;
                    if (m_b4 < 15) m_b4++;
                    if (e && m_e4 < 15) m_e4++;
`ifdef BER_RELOCK_EN
                    win.push_back(e);
                    if (win.size() == 511) begin
                        if (win_errors() > 64) begin m_mode = 1; m_delay = (m_delay + 1) % 511; end
                        win.delete();
                    end
`endif
                end
            endcase
        end
    endtask

    // ---------------- stimulus ----------------
    bit [8:0] prbs = 9'h1AA;
    bit       txq[$];
    int       rx_mode = 0;    // 0 delayed by 5, 1 inverted, 2 constant 0
    int       acc = 0;        // accepted strobes since last reset

    task automatic step(input bit rst, input bit en, input bit vld);
        bit r, x;
        exp_t ex;
        @(negedge clock); #1;
        if (!rst && en && vld) begin
            r = prbs[8];
            prbs = {prbs[7:0], prbs[8] ^ prbs[4]};
            txq.push_front(r);
            if (txq.size() > 8) void'(txq.pop_back());
            x = (txq.size() > 5) ? txq[5] : 1'b0;
            if (rx_mode == 1) x = ~x;
            else if (rx_mode == 2) x = 1'b0;
            acc++;
        end else begin
            r = 1'($urandom);
            x = 1'($urandom);
        end
        if (rst) acc = 0;
        i_reset = rst; i_enable = en; i_valid = vld; i_ref_bit = r; i_rx_bit = x;
        model(rst, en, vld, r, x);
        ex.locked = (m_mode == 2);
        ex.delay  = 9'(m_delay);
        ex.bits   = m_bits;
        ex.errs   = m_errs;
        ex.bz     = ex.locked && (m_errs == 0);
        ex.b4     = m_b4;
        ex.e4     = m_e4;
        ex.bz4    = ex.locked && (m_e4 == 0);
        exp_q.push_back(ex);
    endtask

    task automatic settle();
        @(posedge clock); #3;
    endtask

    task automatic strobes(input int n, input int mode);
        int i = 0;
        bit v;
        rx_mode = mode;
        while (i < n) begin
            v = ($urandom_range(0, 3) != 0);
            step(1'b0, 1'b1, v);
            if (v) i++;
        end
        settle();
    endtask

    task automatic run_until_lock(input int gap_at, input string tag);
        int  cyc = 0;
        bit  gap_done = 0, v;
        rx_mode = 0;
        while (!lk64 && cyc < 8000) begin
            if (acc == gap_at && !gap_done) begin
                gap_done = 1;
                for (int k = 0; k < 100; k++) step(1'b0, 1'b0, k[0]);
            end
            v = ($urandom_range(0, 3) != 0);
            step(1'b0, 1'b1, v);
            settle();
            cyc++;
        end
        cmp({tag, "_locked"}, lk64, 1);
        cmp({tag, "_lock_strobe"}, acc, 3577);
        cmp({tag, "_delay"}, dl64, 5);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clock); #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp("locked", lk64, e.locked);
                cmp("delay", dl64, e.delay);
                cmp("bit_count", bits64, e.bits);
                cmp("error_count", errs64, e.errs);
                cmp("ber_zero", bz64, e.bz);
                cmp("nb4_bit_count", bits4, longint'(e.b4));
                cmp("nb4_error_count", errs4, longint'(e.e4));
                cmp("nb4_ber_zero", bz4, e.bz4);
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, 1'b0);
        settle();
        cmp("rst_locked", lk64, 0);
        cmp("rst_delay", dl64, 0);
        cmp("rst_bits", bits64, 0);
        cmp("rst_errs", errs64, 0);
        cmp("rst_ber_zero", bz64, 0);

        // Lock with a 100-clock enable gap mid-window in the third search window.
        run_until_lock(2000, "lock_gap");

        strobes(50, 0);
        cmp("clean_ber_zero", bz64, 1);
        strobes(10, 1);
        cmp("inv10_errs", errs64, 10);
        cmp("inv10_bits", bits64, 60);
        cmp("inv10_ber_zero", bz64, 0);
        cmp("inv10_nb4_errs", errs4, 10);

        // One-clock reset while locked, with valid and enable also high.
        step(1'b1, 1'b1, 1'b1);
        settle();
        cmp("relrst_locked", lk64, 0);
        cmp("relrst_delay", dl64, 0);
        cmp("relrst_bits", bits64, 0);
        cmp("relrst_errs", errs64, 0);
        cmp("relrst_ber_zero", bz64, 0);

        run_until_lock(-1, "relock");

        strobes(20, 1);
        cmp("sat_nb4_errs", errs4, 15);
        cmp("sat_nb64_errs", errs64, 20);
        strobes(5, 1);
        cmp("sat_hold_nb4_errs", errs4, 15);
        cmp("sat_hold_nb4_bits", bits4, 15);

        strobes(600, 2);
`ifdef BER_RELOCK_EN
        cmp("const0_locked", lk64, 0);
        cmp("const0_delay", dl64, 6);
`else
        cmp("const0_locked", lk64, 1);
        cmp("const0_errs_rising", (errs64 > 100) ? 1 : 0, 1);
`endif

        repeat (4) @(posedge clock);
        #3;
        cmp("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter NB_COUNT, default 64: width of the cumulative bit and error counters.
REQ-002 Parameter LOCK_ERR_MAX, default 0: maximum errors in one search window that still declares lock.
REQ-003 Parameter RELOCK_ERR_MAX, default 64: errors in one locked window above which lock is lost (used only with BER_RELOCK_EN).
REQ-004 clock  input  1  system clock; all logic SHALL sit on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_enable  input  1  when low, all internal state and outputs SHALL hold.
REQ-007 i_valid  input  1  baud strobe, one clock wide; one comparison per strobe.
REQ-008 i_ref_bit  input  1  transmitted PRBS9 bit, qualified by i_valid.
REQ-009 i_rx_bit  input  1  received sign bit, qualified by i_valid.
REQ-010 o_locked  output  1  high while the FSM is in LOCKED.
REQ-011 o_delay  output  9  current candidate or locked delay, in bauds, range 0..510.
REQ-012 o_bit_count  output  NB_COUNT  compared bits since lock.
REQ-013 o_error_count  output  NB_COUNT  mismatched bits since lock.
REQ-014 o_ber_zero  output  1  equals o_locked AND (o_error_count == 0).

Function
REQ-015 A 511-bit reference delay line SHALL shift i_ref_bit in on every qualified strobe (i_valid & i_enable); tap d is the reference bit from d strobes earlier.
REQ-016 The FSM SHALL have exactly three states: FILL, SEARCH, LOCKED.
REQ-017 FILL: count 511 qualified strobes, then enter SEARCH with delay 0 and the window counter cleared.
REQ-018 SEARCH: on each qualified strobe, compare i_rx_bit with tap o_delay, advance a 9-bit window counter 0..510, and accumulate window errors.
REQ-019 Window end in SEARCH (the strobe at window count 510, counting that strobe's own error): if window errors <= LOCK_ERR_MAX, enter LOCKED; otherwise increment o_delay, wrapping 510 to 0, and clear the window.
REQ-020 LOCKED: each qualified strobe SHALL add 1 to o_bit_count and add the mismatch to o_error_count.
REQ-021 Both counters SHALL saturate at all-ones and never wrap.
REQ-022 Counter and o_locked updates SHALL appear on the clock after the qualifying strobe (1-cycle latency).
REQ-023 Strobes with i_enable low SHALL be ignored in every state, including by the delay line.

Reset
REQ-024 While i_reset is high at a clock edge: state becomes FILL; o_delay, o_bit_count, o_error_count, the window counter, and the fill counter become 0; the delay line is cleared; o_locked and o_ber_zero read 0.
REQ-025 Reset SHALL take priority over i_enable and i_valid, in any state and mid-window.

Configuration
REQ-026 Macro BER_RELOCK_EN, when defined: LOCKED runs the same 511-strobe window.
REQ-027 Under BER_RELOCK_EN, window errors > RELOCK_ERR_MAX SHALL force SEARCH with o_delay+1 (wrapping) and a cleared window.
REQ-028 Under BER_RELOCK_EN, cumulative counters SHALL hold their values in SEARCH and resume on relock.
REQ-029 Without BER_RELOCK_EN, LOCKED is terminal until reset, and no locked-window logic is synthesized.

Structure
REQ-030 A shared package SHALL hold: the PRBS9 period constant (511), the 9-bit delay width, and the FSM state encodings.
REQ-031 The delay line with its tap multiplexer SHALL be one sub-module, ber_delay_line.

Verification
REQ-032 Bench check: ref = PRBS9 seed 0x1AA, rx = ref delayed 5 bauds, LOCK_ERR_MAX=0 -> o_locked rises one clock after qualified strobe 3577 (511 fill + 6 windows x 511), with o_delay=5.
REQ-033 Bench check: after lock, invert rx for 10 strobes -> o_error_count=10, o_bit_count increments per strobe, o_ber_zero=0.
REQ-034 Bench check: hold i_enable low for 100 clocks mid-window with i_valid toggling -> all outputs and the window position are unchanged, and the result matches a run without the gap.
REQ-035 Bench check: assert i_reset for one clock while LOCKED with counts nonzero -> next clock shows all outputs 0 and state FILL; relock then occurs at the same strobe count as in REQ-032.
REQ-036 Bench check: NB_COUNT=4, after lock invert rx for 20 strobes -> o_error_count=15, held at saturation.
REQ-037 Bench check: force rx constant 0 after lock -> with BER_RELOCK_EN, o_locked falls at the next window end and o_delay advances by 1; without the macro, o_locked stays high and o_error_count keeps rising.
